// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/result encodings, the
// immediate formats and the ID/EX register layout.
package rv32i_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASSB = 4'd10
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_SHAMT
   } imm_fmt_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       mem_read;
      logic       branch;
      logic       jump;
      logic       jalr;
      logic       alu_src_a;
      logic       alu_src_b;
      logic [1:0] result_src;
      logic [3:0] alu_ctrl;
   } ctrl_t;

   typedef struct packed {
      logic        valid;
      ctrl_t       ctrl;
      logic [2:0]  funct3;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        illegal;
   } idex_t;

   // Register-register / register-immediate ALU op selected by funct3 alone.
   function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3);
      logic [3:0] a;
      case (f3)
         3'b000:  a = ALU_ADD;
         3'b001:  a = ALU_SLL;
         3'b010:  a = ALU_SLT;
         3'b011:  a = ALU_SLTU;
         3'b100:  a = ALU_XOR;
         3'b101:  a = ALU_SRL;
         3'b110:  a = ALU_OR;
         default: a = ALU_AND;
      endcase
      return a;
   endfunction

   function automatic logic [31:0] imm_gen(input logic [31:7] instr, input imm_fmt_e fmt);
      logic [31:0] imm;
      case (fmt)
         IMM_I:     imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:     imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:     imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:     imm = {instr[31:12], 12'h000};
         IMM_J:     imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_SHAMT: imm = {27'd0, instr[24:20]};
         default:   imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 integer register file: two combinational read ports with write-first
// bypass, one write port, x0 hard-wired to zero, asynchronous clear.
module reg_file
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra1_i,
   input  logic [4:0]  ra2_i,
   output logic [31:0] rd1_o,
   output logic [31:0] rd2_o,
   input  logic        we_i,
   input  logic [4:0]  wa_i,
   input  logic [31:0] wd_i
);

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   always_comb begin
      regs_d = regs_q;
      if (we_i && (wa_i != 5'd0)) regs_d[wa_i] = wd_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Write-first: a same-cycle write-back is visible to the decode reading it.
   always_comb begin
      rd1_o = 32'd0;
      rd2_o = 32'd0;
      if (ra1_i != 5'd0) rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
      if (ra2_i != 5'd0) rd2_o = (we_i && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: register file, decoder, immediate generator
// and the ID/EX pipeline register, with illegal-encoding detection.
module decode_stage
   import rv32i_pkg::*;
#(
   parameter int XLEN = 32
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            ValidD,
   input  logic [XLEN-1:0] InstrD,
   input  logic [XLEN-1:0] PCD,
   input  logic [XLEN-1:0] PCPlus4D,
   input  logic            StallD,
   input  logic            FlushE,
   input  logic            RegWriteW,
   input  logic [4:0]      RdW,
   input  logic [XLEN-1:0] ResultW,
   output logic [4:0]      Rs1D,
   output logic [4:0]      Rs2D,
   output logic            ValidE,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            MemReadE,
   output logic            BranchE,
   output logic            JumpE,
   output logic            JalrE,
   output logic            ALUSrcAE,
   output logic            ALUSrcBE,
   output logic [1:0]      ResultSrcE,
   output logic [3:0]      ALUControlE,
   output logic [2:0]      Funct3E,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic [4:0]      Rs1E,
   output logic [4:0]      Rs2E,
   output logic [4:0]      RdE,
   output logic            IllegalOp
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] rd1, rd2;
   ctrl_t       ctrl;
   imm_fmt_e    fmt;
   logic        illegal;
   idex_t       ex_d, ex_q;

   assign opcode = InstrD[6:0];
   assign funct3 = InstrD[14:12];
   assign funct7 = InstrD[31:25];
   assign Rs1D   = InstrD[19:15];
   assign Rs2D   = InstrD[24:20];

   reg_file u_rf (
      .clk   (clk),
      .rst   (rst),
      .ra1_i (Rs1D),
      .ra2_i (Rs2D),
      .rd1_o (rd1),
      .rd2_o (rd2),
      .we_i  (RegWriteW),
      .wa_i  (RdW),
      .wd_i  (ResultW)
   );

   always_comb begin
      ctrl    = '0;
      fmt     = IMM_NONE;
      illegal = 1'b0;
      case (opcode)
         OPC_LUI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src_b = 1'b1;
            ctrl.alu_ctrl  = ALU_PASSB;
            fmt            = IMM_U;
         end
         OPC_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 1'b1;
            fmt            = IMM_U;
         end
         OPC_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = 1'b1;
            ctrl.result_src = RES_PC4;
            fmt             = IMM_J;
         end
         OPC_JALR: begin
            ctrl.reg_write  = 1'b1;
            ctrl.jump       = 1'b1;
            ctrl.jalr       = 1'b1;
            ctrl.alu_src_b  = 1'b1;
            ctrl.result_src = RES_PC4;
            fmt             = IMM_I;
            illegal         = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            ctrl.branch   = 1'b1;
            ctrl.alu_ctrl = ALU_SUB;
            fmt           = IMM_B;
            illegal       = (funct3 == 3'b010) || (funct3 == 3'b011);
         end
         OPC_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.alu_src_b  = 1'b1;
            ctrl.result_src = RES_MEM;
            fmt             = IMM_I;
            illegal         = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPC_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src_b = 1'b1;
            fmt            = IMM_S;
            illegal        = (funct3 >= 3'b011);
         end
         OPC_OP_IMM: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src_b = 1'b1;
            ctrl.alu_ctrl  = alu_from_funct3(funct3);
            fmt            = IMM_I;
            if (funct3 == 3'b001) begin
               fmt     = IMM_SHAMT;
               illegal = (funct7 != F7_ZERO);
            end else if (funct3 == 3'b101) begin
               fmt           = IMM_SHAMT;
               ctrl.alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
               illegal       = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
            end
         end
         OPC_OP: begin
            ctrl.reg_write = 1'b1;
            if (funct7 == F7_ZERO)                        ctrl.alu_ctrl = alu_from_funct3(funct3);
            else if (funct7 == F7_ALT && funct3 == 3'b000) ctrl.alu_ctrl = ALU_SUB;
            else if (funct7 == F7_ALT && funct3 == 3'b101) ctrl.alu_ctrl = ALU_SRA;
            else                                          illegal = 1'b1;
         end
         OPC_FENCE, OPC_SYSTEM: ;
         default: illegal = 1'b1;
      endcase
      if (InstrD[1:0] != 2'b11) illegal = 1'b1;
   end

   // Flush beats stall; an invalid slot or a flush loads an all-zero bubble.
   always_comb begin
      ex_d = ex_q;
      if (FlushE) begin
         ex_d = '0;
      end else if (!StallD) begin
         ex_d = '0;
         if (ValidD) begin
            ex_d.valid    = 1'b1;
            ex_d.ctrl     = ctrl;
            ex_d.funct3   = funct3;
            ex_d.rd1      = rd1;
            ex_d.rd2      = rd2;
            ex_d.imm      = imm_gen(InstrD[31:7], fmt);
            ex_d.pc       = PCD;
            ex_d.pc_plus4 = PCPlus4D;
            ex_d.rs1      = Rs1D;
            ex_d.rs2      = Rs2D;
            ex_d.rd       = InstrD[11:7];
            ex_d.illegal  = illegal;
            if (illegal) begin
               ex_d.ctrl.reg_write = 1'b0;
               ex_d.ctrl.mem_write = 1'b0;
               ex_d.ctrl.mem_read  = 1'b0;
               ex_d.ctrl.branch    = 1'b0;
               ex_d.ctrl.jump      = 1'b0;
               ex_d.ctrl.jalr      = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ex_q <= '0;
      else     ex_q <= ex_d;
   end

   assign ValidE      = ex_q.valid;
   assign RegWriteE   = ex_q.ctrl.reg_write;
   assign MemWriteE   = ex_q.ctrl.mem_write;
   assign MemReadE    = ex_q.ctrl.mem_read;
   assign BranchE     = ex_q.ctrl.branch;
   assign JumpE       = ex_q.ctrl.jump;
   assign JalrE       = ex_q.ctrl.jalr;
   assign ALUSrcAE    = ex_q.ctrl.alu_src_a;
   assign ALUSrcBE    = ex_q.ctrl.alu_src_b;
   assign ResultSrcE  = ex_q.ctrl.result_src;
   assign ALUControlE = ex_q.ctrl.alu_ctrl;
   assign Funct3E     = ex_q.funct3;
   assign RD1E        = ex_q.rd1;
   assign RD2E        = ex_q.rd2;
   assign ImmExtE     = ex_q.imm;
   assign PCE         = ex_q.pc;
   assign PCPlus4E    = ex_q.pc_plus4;
   assign Rs1E        = ex_q.rs1;
   assign Rs2E        = ex_q.rs2;
   assign RdE         = ex_q.rd;
   assign IllegalOp   = ex_q.illegal;

endmodule
